// File: rtl/panel_loader.sv
// panel_loader: drives a front panel's switches and buttons to deposit a program image into memory
// word by word, then loads the start PC, starts the CPU and waits for it to halt.
//
// Each panel action has three phases: set the switches, press the button, release it. Every phase
// lasts HOLD cycles. When a word's address follows the last deposited address, the address load is
// skipped because deposit auto-increments the panel PC.
//
// Ports:
//   clock        system clock; all state changes on the rising edge
//   resetN       asynchronous active-low reset
//   in_valid     image word offered
//   in_ready     loader accepts a word this cycle (high only in idle)
//   in_addr      target memory address
//   in_data      word to deposit
//   in_last      final word of the image
//   run_led      panel "running" lamp
//   sw           panel switches: [11:0] value, [12] run
//   btnl         load-PC button
//   btnd         deposit button
//   busy         sequence in progress (not idle, not done)
//   done         program halted after run (sticky until reset)
//   words_loaded number of completed deposits, saturating at 4096
module panel_loader #(
  parameter int unsigned HOLD     = 10,
  parameter logic [11:0] START_PC = 12'o0200
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_addr,
  input  logic [11:0] in_data,
  input  logic        in_last,
  input  logic        run_led,
  output logic [12:0] sw,
  output logic        btnl,
  output logic        btnd,
  output logic        busy,
  output logic        done,
  output logic [12:0] words_loaded
);

  typedef enum logic [3:0] {
    StIdle, StASet, StAPrs, StARel, StDSet, StDPrs, StDRel,
    StPSet, StPPrs, StPRel, StRun, StDone
  } state_e;

  localparam logic [7:0]  PhaseLast = 8'(HOLD - 1);
  localparam logic [12:0] MaxWords  = 13'd4096;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] data_q, data_d;
  logic        last_q, last_d;
  logic [11:0] prev_addr_q, prev_addr_d;
  logic        have_prev_q, have_prev_d;
  logic        seen_q, seen_d;
  logic [12:0] words_q, words_d;

  // Registered outputs, decoded from next-state values.
  logic [12:0] sw_q, sw_d;
  logic        btnl_q, btnl_d;
  logic        btnd_q, btnd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

  logic        phase_end;
  logic        in_phase;
  logic [11:0] next_addr;

  assign phase_end = (cnt_q == PhaseLast);
  assign next_addr = prev_addr_q + 12'd1;  // wraps 7777 -> 0000

  always_comb begin
    in_phase = 1'b0;
    unique case (state_q)
      StASet, StAPrs, StARel, StDSet, StDPrs, StDRel, StPSet, StPPrs, StPRel: in_phase = 1'b1;
      default: in_phase = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    prev_addr_d = prev_addr_q;
    have_prev_d = have_prev_q;
    seen_d      = seen_q;
    words_d     = words_q;
    cnt_d       = 8'd0;

    if (in_phase && !phase_end) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        // in_ready is high exactly in idle, so in_valid alone marks a transfer here.
        if (in_valid) begin
          addr_d  = in_addr;
          data_d  = in_data;
          last_d  = in_last;
          state_d = (have_prev_q && (in_addr == next_addr)) ? StDSet : StASet;
        end
      end
      StASet: if (phase_end) state_d = StAPrs;
      StAPrs: if (phase_end) state_d = StARel;
      StARel: if (phase_end) state_d = StDSet;
      StDSet: if (phase_end) state_d = StDPrs;
      StDPrs: if (phase_end) state_d = StDRel;
      StDRel: begin
        if (phase_end) begin
          words_d     = (words_q == MaxWords) ? words_q : words_q + 13'd1;
          prev_addr_d = addr_q;
          have_prev_d = 1'b1;
          state_d     = last_q ? StPSet : StIdle;
        end
      end
      StPSet: if (phase_end) state_d = StPPrs;
      StPPrs: if (phase_end) state_d = StPRel;
      StPRel: begin
        if (phase_end) begin
          seen_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Halt is the first low lamp after it has been seen lit in this run.
        if (run_led) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    sw_d    = 13'd0;
    btnl_d  = 1'b0;
    btnd_d  = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    ready_d = 1'b0;
    case (state_d)
      StIdle: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      StASet, StARel: sw_d = {1'b0, addr_d};
      StAPrs: begin
        sw_d   = {1'b0, addr_d};
        btnl_d = 1'b1;
      end
      StDSet, StDRel: sw_d = {1'b0, data_d};
      StDPrs: begin
        sw_d   = {1'b0, data_d};
        btnd_d = 1'b1;
      end
      StPSet, StPRel: sw_d = {1'b0, START_PC};
      StPPrs: begin
        sw_d   = {1'b0, START_PC};
        btnl_d = 1'b1;
      end
      StRun: sw_d = 13'h1000;
      StDone: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      addr_q      <= 12'd0;
      data_q      <= 12'd0;
      last_q      <= 1'b0;
      prev_addr_q <= 12'd0;
      have_prev_q <= 1'b0;
      seen_q      <= 1'b0;
      words_q     <= 13'd0;
      sw_q        <= 13'd0;
      btnl_q      <= 1'b0;
      btnd_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      prev_addr_q <= prev_addr_d;
      have_prev_q <= have_prev_d;
      seen_q      <= seen_d;
      words_q     <= words_d;
      sw_q        <= sw_d;
      btnl_q      <= btnl_d;
      btnd_q      <= btnd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign sw           = sw_q;
  assign btnl         = btnl_q;
  assign btnd         = btnd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign in_ready     = ready_q;
  assign words_loaded = words_q;

endmodule

// File: doc/panel_loader.md
PANEL_LOADER -- requirements
Module: panel_loader

Interface
REQ-001 SHALL have parameter HOLD, default 10, the cycles each panel phase (setup, press, release) lasts; legal range 1..255.
REQ-002 SHALL have parameter START_PC, default 12'o0200, the PC loaded before run.
REQ-003 SHALL have ports: clock  in  1  system clock, all state on rising edge.
REQ-004 SHALL have ports: resetN  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: in_valid  in  1  image word offered.
REQ-006 SHALL have ports: in_ready  out  1  loader accepts word this cycle.
REQ-007 SHALL have ports: in_addr  in  12  target memory address.
REQ-008 SHALL have ports: in_data  in  12  word to deposit.
REQ-009 SHALL have ports: in_last  in  1  final word of image.
REQ-010 SHALL have ports: run_led  in  1  Front_Panel led[12], CPU running.
REQ-011 SHALL have ports: sw  out  13  Front_Panel switches; [11:0] value, [12] run.
REQ-012 SHALL have ports: btnl  out  1  load-PC button.
REQ-013 SHALL have ports: btnd  out  1  deposit button.
REQ-014 SHALL have ports: busy  out  1  high in any state except IDLE and DONE.
REQ-015 SHALL have ports: done  out  1  program halted after run.
REQ-016 SHALL have ports: words_loaded  out  13  count of deposits completed (0..4096).

Function
REQ-017 SHALL implement states IDLE, A_SET, A_PRS, A_REL, D_SET, D_PRS, D_REL, P_SET, P_PRS, P_REL, RUN, DONE.
REQ-018 SHALL use one phase counter: every state except IDLE, RUN and DONE lasts exactly HOLD cycles, then advances.
REQ-019 SHALL assert in_ready only in IDLE; transfer occurs on rising edge with in_valid && in_ready; addr, data, last captured into registers.
REQ-020 SHALL, on transfer, enter D_SET if a prior deposit exists and in_addr == (last deposited addr + 1) mod 4096 (deposit auto-increments PC; 7777->0000 counts as sequential), else A_SET.
REQ-021 SHALL drive sw[11:0]=captured addr in A_SET/A_PRS/A_REL; btnl=1 only in A_PRS.
REQ-022 SHALL drive sw[11:0]=captured data in D_SET/D_PRS/D_REL; btnd=1 only in D_PRS.
REQ-023 SHALL, on D_REL exit, increment words_loaded (saturate at 4096), record addr as last deposited, go to P_SET if captured last=1 else IDLE.
REQ-024 SHALL drive sw[11:0]=START_PC in P_SET/P_PRS/P_REL; btnl=1 only in P_PRS.
REQ-025 SHALL, in RUN, drive sw[12]=1; leave RUN to DONE on first cycle run_led is 0 after having been sampled 1 in RUN.
REQ-026 SHALL hold sw[12]=0 in all states except RUN; btnl and btnd never both 1.
REQ-027 SHALL keep DONE sticky with done=1, in_ready=0, buttons released, sw=0, until resetN.
REQ-028 SHALL ignore in_valid outside IDLE; in_data/in_addr changes after transfer have no effect.
REQ-029 SHALL make outputs registered-state decodes only; no combinational path in_valid->in_ready.
REQ-030 SHALL cost 6*HOLD cycles per non-sequential word, 3*HOLD per sequential word, 3*HOLD for PC load.

Reset
REQ-031 SHALL, while resetN=0, force state IDLE, phase counter 0, sw=0, btnl=0, btnd=0, busy=0, done=0, words_loaded=0, no prior deposit; in_ready=1 after release.
REQ-032 SHALL abort any in-flight sequence on resetN mid-operation, releasing buttons immediately (asynchronously); the interrupted word is not counted.

Verification
REQ-033 SHALL pass: HOLD=10, single word addr 0200 data 7402 last=1 -> btnl pulse 10 cycles sw=0200, btnd pulse 10 cycles sw=7402, words_loaded=1, btnl pulse with sw=0200, then sw[12]=1.
REQ-034 SHALL pass: words at 0200,0201,0202 -> btnl pulses only for first word and PC load; 3 btnd pulses; 90+30 cycles before P_SET.
REQ-035 SHALL pass: words at 7777 then 0000 -> second word takes sequential path (no btnl); words at 0100 then 0300 -> both take A_SET.
REQ-036 SHALL pass: in RUN, run_led 0->1 held 50 cycles then 0 -> DONE next cycle, done=1, sw[12]=0; further in_valid ignored.
REQ-037 SHALL pass: resetN low during D_PRS of word 2 -> btnd=0 same cycle, words_loaded=0, in_ready=1 after release; reload completes normally.
REQ-038 SHALL pass: in_valid held high with random stall gaps -> each word accepted exactly once, in order.
